// File: rtl/hps_pio_responder.sv
// hps_pio_responder: Avalon-MM register block for the board switches and LEDs.
// Switches are synchronised, debounced per bit and edge-captured into a
// maskable level interrupt. LEDs are driven from a register with
// write, bit-set and bit-clear access. Reads have a fixed latency of one cycle.
module hps_pio_responder #(
    parameter int               WIDTH           = 10,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] LED_RESET       = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic [3:0]       avs_byteenable,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] led_out,
    output logic             irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]      ID_VALUE = 32'h5057_0001;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_LED  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;
    localparam logic [2:0] ADDR_ID   = 3'd6;

    // ------------------------------------------------------------------
    // Switch input path
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] deb_q;       // debounced switch state (DATA)
    logic [WIDTH-1:0] deb_prev_q;  // debounced state one cycle ago, for edge detect

    // Two-flop synchroniser on the raw asynchronous switch pins
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

    // One independent debouncer per switch bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             deb_bit_q;
        logic             deb_bit_d;

        // Count consecutive cycles of disagreement; any agreement restarts
        // the count, and the final count both commits the bit and clears.
        always_comb begin
            cnt_d     = '0;
            deb_bit_d = deb_bit_q;
            if (sync2_q[gi] != deb_bit_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_bit_d = sync2_q[gi];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Debounce counter and debounced bit registers
        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                cnt_q     <= '0;
                deb_bit_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                deb_bit_q <= deb_bit_d;
            end
        end

        assign deb_q[gi] = deb_bit_q;
    end

    // ------------------------------------------------------------------
    // Byte-lane write mask
    // ------------------------------------------------------------------
    logic [31:0]      be_mask;
    logic [WIDTH-1:0] be_bits;   // register bits this write may touch
    logic [WIDTH-1:0] wr_bits;   // write data restricted to enabled lanes

    for (genvar gi = 0; gi < 32; gi++) begin : g_be_mask
        assign be_mask[gi] = avs_byteenable[gi / 8];
    end

    assign be_bits = be_mask[WIDTH-1:0];
    assign wr_bits = avs_writedata[WIDTH-1:0] & be_bits;

    // Data bits above WIDTH-1 and lanes beyond the register width are ignored
    logic unused_bits;
    assign unused_bits = ^{avs_writedata, be_mask};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] led_q,  led_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_clr;
    logic             irq_q,  irq_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             rd_accept;
    logic [31:0]      rd_mux;

    // A read that collides with a write is dropped
    assign rd_accept = avs_read & ~avs_write;

    // Write decode and next-state for LED, MASK, EDGE and the interrupt
    always_comb begin
        led_d    = led_q;
        mask_d   = mask_q;
        edge_clr = '0;
        if (avs_write) begin
            case (avs_address)
                ADDR_LED:  led_d    = (led_q & ~be_bits) | wr_bits;
                ADDR_MASK: mask_d   = (mask_q & ~be_bits) | wr_bits;
                ADDR_EDGE: edge_clr = wr_bits;
                ADDR_SET:  led_d    = led_q | wr_bits;
                ADDR_CLR:  led_d    = led_q & ~wr_bits;
                default:   ;
            endcase
        end
        // New edges are ORed in after the clear so a coincident set wins
        edge_d = (edge_q & ~edge_clr) | (deb_q ^ deb_prev_q);
        irq_d  = |(edge_q & mask_q);
    end

    // Read data selection; unmapped and write-only addresses return 0
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_DATA: rd_mux = 32'(deb_q);
            ADDR_LED:  rd_mux = 32'(led_q);
            ADDR_MASK: rd_mux = 32'(mask_q);
            ADDR_EDGE: rd_mux = 32'(edge_q);
            ADDR_ID:   rd_mux = ID_VALUE;
            default:   rd_mux = '0;
        endcase
    end

    // Read response: data is held only for the single valid cycle
    always_comb begin
        rvalid_d = rd_accept;
        rdata_d  = rd_accept ? rd_mux : 32'h0;
    end

    // Register state and bus response
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led_q      <= LED_RESET;
            mask_q     <= '0;
            edge_q     <= '0;
            deb_prev_q <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            led_q      <= led_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            deb_prev_q <= deb_q;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign led_out           = led_q;
    assign irq               = irq_q;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_hps_pio_responder.sv
// Testbench for hps_pio_responder: scoreboarded read responses plus
// inline checks of led_out and irq, one task per scenario.
module tb_hps_pio_responder;

    localparam int W = 10;

    logic          clk_clk;
    logic          reset_reset_n;
    logic [2:0]    avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic [W-1:0]  sw_in;
    logic [W-1:0]  led_out;
    logic          irq;

    int vectors;
    int miscompares;

    logic [31:0] exp_q [$];
    logic        mon_ev;
    logic [31:0] mon_exp;

    hps_pio_responder #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (16),
        .LED_RESET       (10'h000)
    ) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .sw_in             (sw_in),
        .led_out           (led_out),
        .irq               (irq)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // Scoreboard: a read accepted at an edge must produce valid right after it
    always @(posedge clk_clk) begin
        mon_ev = reset_reset_n && avs_read && !avs_write;
        #1;
        vectors++;
        if (avs_readdatavalid !== mon_ev) begin
            miscompares++;
            $display("FAIL rvalid: got %b expected %b at %0t", avs_readdatavalid, mon_ev, $time);
        end
        if (mon_ev) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rdata_queue: got read with no expected entry at %0t", $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (avs_readdata !== mon_exp) begin
                    miscompares++;
                    $display("FAIL rdata: got %h expected %h at %0t", avs_readdata, mon_exp, $time);
                end else begin
                    $display("read ok: data %h at %0t", avs_readdata, $time);
                end
            end
        end else begin
            vectors++;
            if (avs_readdata !== 32'h0) begin
                miscompares++;
                $display("FAIL rdata_idle: got %h expected %h at %0t", avs_readdata, 32'h0, $time);
            end
        end
    end

    // One bus cycle, driven just after a falling edge; returns at the next one
    task automatic cyc(input logic rd, input logic wr, input logic [2:0] a,
                       input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = a;
        avs_writedata  = wd;
        avs_byteenable = be;
        if (rd && !wr) exp_q.push_back(exp);
        @(negedge clk_clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'h0, 4'hF, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
        cyc(1'b0, 1'b1, a, wd, be, 32'h0);
        $display("write: addr %0d data %h be %h led %h irq %b", a, wd, be, led_out, irq);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic check_led(input string name, input logic [W-1:0] exp);
        vectors++;
        if (led_out !== exp) begin
            miscompares++;
            $display("FAIL %s: led_out got %h expected %h", name, led_out, exp);
        end
    endtask

    task automatic check_irq(input string name, input logic exp);
        vectors++;
        if (irq !== exp) begin
            miscompares++;
            $display("FAIL %s: irq got %b expected %b", name, irq, exp);
        end
    endtask

    task automatic test_reset();
        reset_reset_n  = 1'b0;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_address    = 3'd0;
        avs_writedata  = 32'h0;
        avs_byteenable = 4'h0;
        sw_in          = '0;
        repeat (3) @(negedge clk_clk);
        check_led("reset_led", 10'h000);
        check_irq("reset_irq", 1'b0);
        reset_reset_n = 1'b1;
        rd(3'd6, 32'h5057_0001);
        rd(3'd0, 32'h0);
        idle();
        rd(3'd7, 32'h0);
        check_led("reset_led_after", 10'h000);
        check_irq("reset_irq_after", 1'b0);
    endtask

    task automatic test_led();
        wr(3'd1, 32'h0000_02A5, 4'hF);
        check_led("led_write", 10'h2A5);
        wr(3'd4, 32'h0000_000A, 4'hF);
        check_led("led_set", 10'h2AF);
        wr(3'd5, 32'h0000_0005, 4'hF);
        check_led("led_clr", 10'h2AA);
        rd(3'd1, 32'h0000_02AA);
        wr(3'd1, 32'h0000_03FF, 4'b0010);
        check_led("led_be_hi", 10'h3AA);
        wr(3'd1, 32'h0000_0000, 4'b0001);
        check_led("led_be_lo", 10'h300);
        wr(3'd1, 32'hFFFF_FD55, 4'hF);
        check_led("led_upper_ignored", 10'h155);
        rd(3'd1, 32'h0000_0155);
        rd(3'd4, 32'h0);
        rd(3'd5, 32'h0);
        wr(3'd0, 32'h0000_03FF, 4'hF);
        rd(3'd0, 32'h0);
    endtask

    task automatic test_debounce();
        sw_in[3] = 1'b1;
        for (int i = 0; i < 10; i++) rd(3'd0, 32'h0);
        sw_in[3] = 1'b0;
        for (int i = 0; i < 5; i++) rd(3'd0, 32'h0);
        sw_in[3] = 1'b1;
        // reads sampled at edges 1..18 after the stable change see DATA=0
        for (int e = 1; e <= 18; e++) rd(3'd0, 32'h0);
        rd(3'd3, 32'h0);          // edge 19: EDGE sets this cycle, read sees old value
        rd(3'd3, 32'h0000_0008);  // edge 20
        rd(3'd0, 32'h0000_0008);  // edge 21
        for (int i = 0; i < 9; i++) idle();
    endtask

    task automatic test_irq();
        wr(3'd2, 32'h0000_0008, 4'hF);
        check_irq("irq_mask_same", 1'b0);
        idle();
        check_irq("irq_mask_next", 1'b1);
        wr(3'd3, 32'h0000_0008, 4'hF);
        check_irq("irq_w1c_same", 1'b1);
        idle();
        check_irq("irq_w1c_next", 1'b0);
        rd(3'd3, 32'h0);
        sw_in[3] = 1'b0;
        repeat (19) idle();
        idle();
        check_irq("irq_fall_edge", 1'b1);
        wr(3'd3, 32'h0000_0000, 4'hF);
        wr(3'd2, 32'h0000_0000, 4'hF);
        check_irq("irq_unmask_same", 1'b1);
        idle();
        check_irq("irq_unmask_next", 1'b0);
        rd(3'd3, 32'h0000_0008);
        rd(3'd2, 32'h0);
    endtask

    task automatic test_collision();
        wr(3'd3, 32'h0000_0008, 4'hF);
        rd(3'd3, 32'h0);
        sw_in[3] = 1'b1;
        repeat (18) idle();
        wr(3'd3, 32'h0000_0008, 4'hF);   // lands in the same cycle EDGE[3] sets
        rd(3'd3, 32'h0000_0008);
        rd(3'd0, 32'h0000_0008);
        // read and write together: write lands, no response
        cyc(1'b1, 1'b1, 3'd2, 32'h0000_03FF, 4'hF, 32'h0);
        rd(3'd2, 32'h0000_03FF);
        check_irq("collision_irq", 1'b1);
    endtask

    task automatic test_reset_mid();
        wr(3'd1, 32'h0000_00F0, 4'hF);
        sw_in[5] = 1'b1;
        repeat (8) idle();
        rd(3'd1, 32'h0000_00F0);
        avs_read      = 1'b1;
        avs_address   = 3'd1;
        reset_reset_n = 1'b0;
        #1;
        vectors++;
        if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_bus: got valid %b data %h expected 0 0", avs_readdatavalid, avs_readdata);
        end
        check_led("reset_mid_led", 10'h000);
        check_irq("reset_mid_irq", 1'b0);
        @(negedge clk_clk);
        @(negedge clk_clk);
        avs_read      = 1'b0;
        reset_reset_n = 1'b1;
        for (int e = 1; e <= 18; e++) rd(3'd0, 32'h0);
        rd(3'd0, 32'h0000_0028);
        rd(3'd3, 32'h0000_0028);
        rd(3'd2, 32'h0);
        idle();
        check_irq("reset_mid_irq_after", 1'b0);
        check_led("reset_mid_led_after", 10'h000);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_led();
        test_debounce();
        test_irq();
        test_collision();
        test_reset_mid();
        repeat (2) idle();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
